// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared VGA timing constants and helpers.
//   - Default 640x480@60 timing in pixel clocks and lines.
//   - Functions that derive the total period and the sync window from the four
//     timing segments. Both the default constants and the overridable module
//     parameters in vga_sync_gen use these functions.
//   - Counter width, plus small counter helpers used by the sync generator.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  function automatic int timing_total(input int disp, input int front,
                                      input int sync, input int back);
    return disp + front + sync + back;
  endfunction

  // First count of the sync pulse.
  function automatic int sync_start(input int disp, input int front);
    return disp + front;
  endfunction

  // Last count of the sync pulse (inclusive).
  function automatic int sync_end(input int disp, input int front, input int sync);
    return disp + front + sync - 1;
  endfunction

  localparam int H_TOTAL_DEF      = timing_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF      = timing_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);
  localparam int H_SYNC_START_DEF = sync_start(H_DISPLAY_DEF, H_FRONT_DEF);
  localparam int H_SYNC_END_DEF   = sync_end(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF);
  localparam int V_SYNC_START_DEF = sync_start(V_DISPLAY_DEF, V_FRONT_DEF);
  localparam int V_SYNC_END_DEF   = sync_end(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF);

  function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] cnt,
                                                input logic [CNT_W-1:0] last);
    return (cnt == last) ? '0 : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// -----------------------------------------------------------------------------
// pixel_tick_gen
// Divides the system clock by four to produce a one-clock pixel enable.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset; clears the divider
//   p_tick out  high for one clk out of every four (divider count == 3)
// After reset releases the divider counts 1,2,3, so the first p_tick is
// visible in the cycle before the fourth clk edge and is consumed by it.
// -----------------------------------------------------------------------------
module pixel_tick_gen (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  assign cnt_d = cnt_q + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign p_tick = (cnt_q == 2'd3);

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// VGA horizontal/vertical timing generator running from the system clock with
// a divide-by-four pixel enable.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset; abandons any frame in progress
//   hsync    out  horizontal sync, active-low, registered
//   vsync    out  vertical sync, active-low, registered
//   video_on out  high while (pixel_x, pixel_y) is inside the visible area
//   p_tick   out  one-clk pixel enable
//   pixel_x  out  horizontal position (counter register)
//   pixel_y  out  vertical position (counter register)
// -----------------------------------------------------------------------------
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic             clk,
  input  logic             reset,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             p_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y
);

  localparam int H_TOTAL = timing_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = timing_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(sync_start(H_DISPLAY, H_FRONT));
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(sync_end(H_DISPLAY, H_FRONT, H_SYNC));
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(sync_start(V_DISPLAY, V_FRONT));
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(sync_end(V_DISPLAY, V_FRONT, V_SYNC));

  logic             tick;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             hsync_q;
  logic             vsync_q;

  pixel_tick_gen u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (tick)
  );

  // The vertical counter steps only on the tick that wraps the line.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      h_d = wrap_inc(h_q, H_LAST);
      if (h_q == H_LAST) begin
        v_d = wrap_inc(v_q, V_LAST);
      end
    end
  end

  // Syncs are decoded from the next-state counts so the registered pulses
  // line up with pixel_x/pixel_y in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= ~in_window(h_d, HS_START, HS_END);
      vsync_q <= ~in_window(v_d, VS_START, VS_END);
    end
  end

  assign pixel_x  = h_q;
  assign pixel_y  = v_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign p_tick   = tick;
  assign video_on = (h_q < H_VIS) && (v_q < V_VIS);

endmodule
